// File: rtl/neural_compressor_pkg.sv
// Shared types and constants for the neural delta/run compression link.
// Packet-type codes are common to the compressor and the decompressor.
package neural_compressor_pkg;

  localparam int DATA_WIDTH = 16;

  localparam logic [1:0] PKT_DELTA   = 2'b00;
  localparam logic [1:0] PKT_RUN     = 2'b01;
  localparam logic [1:0] PKT_SPIKE   = 2'b10;
  localparam logic [1:0] PKT_LITERAL = 2'b11;

  typedef enum logic {
    S_PASS,
    S_RUN
  } run_state_e;

  typedef struct packed {
    logic [15:0] sample_count;
    logic [15:0] spike_count;
    logic [15:0] run_count;
    logic        no_ref_err;
  } decomp_stats_t;

endpackage

// File: rtl/delta_decompressor_if.sv
// Packet-in / sample-out valid/ready bundle of the delta decompressor.
// The slave modport is the decompressor side.
interface delta_decompressor_if
  import neural_compressor_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH
);

  logic [DATA_W-1:0] packet_in;
  logic [1:0]        packet_type;
  logic              valid_in;
  logic              ready_out;
  logic [DATA_W-1:0] data_out;
  logic              spike_out;
  logic              valid_out;
  logic              ready_in;

  modport slave (
    input  packet_in, packet_type, valid_in, ready_in,
    output ready_out, data_out, spike_out, valid_out
  );

  modport master (
    output packet_in, packet_type, valid_in, ready_in,
    input  ready_out, data_out, spike_out, valid_out
  );

endinterface

// File: rtl/delta_run_expander.sv
// Run-length expansion control: run counter, PASS/RUN FSM, input ready.
// run_load asks the top to (re)present the reference sample.
module delta_run_expander
  import neural_compressor_pkg::*;
#(
  parameter int RUN_W = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_req,
  input  logic [RUN_W-1:0] run_n,
  input  logic             valid_out,
  input  logic             ready_in,
  output logic             ready_out,
  output logic             run_load
);

  run_state_e       state, state_nx;
  logic [RUN_W-1:0] run_cnt, run_cnt_nx;

  assign ready_out = (state == S_PASS)
                   && (!valid_out || ready_in);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_PASS;
      run_cnt <= '0;
    end else begin
      state   <= state_nx;
      run_cnt <= run_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    run_cnt_nx = run_cnt;
    run_load   = 1'b0;
    unique case (state)
      S_PASS: begin
        if (run_req && ready_out && run_n != '0) begin
          run_load   = 1'b1;
          run_cnt_nx = run_n - RUN_W'(1);
          if (run_n != RUN_W'(1)) state_nx = S_RUN;
        end
      end
      S_RUN: begin
        // next copy goes out as the current one is taken
        if (valid_out && ready_in) begin
          run_load   = 1'b1;
          run_cnt_nx = run_cnt - RUN_W'(1);
          if (run_cnt == RUN_W'(1)) state_nx = S_PASS;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/delta_decompressor.sv
// Delta/run packet decompressor: rebuilds samples and spike flags.
// Define DECOMP_STATS_EN to enable the sample/spike/run counters.
module delta_decompressor
  import neural_compressor_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int RUN_W  = DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  delta_decompressor_if.slave  bus,
  output decomp_stats_t        stats
);

  logic [DATA_W-1:0] prev, sum, data_q;
  logic spike_q, valid_q, has_ref, no_ref_err;
  logic ready, run_load, acc, xfer;
  logic is_delta, is_run, is_spike, is_lit;

  assign is_delta = bus.packet_type == PKT_DELTA;
  assign is_run   = bus.packet_type == PKT_RUN;
  assign is_spike = bus.packet_type == PKT_SPIKE;
  assign is_lit   = bus.packet_type == PKT_LITERAL;

  assign acc  = bus.valid_in && ready;
  assign xfer = valid_q && bus.ready_in;
  assign sum  = prev + bus.packet_in;

  assign bus.ready_out = ready;
  assign bus.data_out  = data_q;
  assign bus.spike_out = spike_q;
  assign bus.valid_out = valid_q;

  delta_run_expander #(.RUN_W(RUN_W)) u_exp (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_req   (bus.valid_in && is_run),
    .run_n     (bus.packet_in[RUN_W-1:0]),
    .valid_out (valid_q),
    .ready_in  (bus.ready_in),
    .ready_out (ready),
    .run_load  (run_load)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q     <= '0;
      spike_q    <= 1'b0;
      valid_q    <= 1'b0;
      prev       <= '0;
      has_ref    <= 1'b0;
      no_ref_err <= 1'b0;
    end else begin
      if (xfer) valid_q <= 1'b0;
      if (acc) begin
        unique case (1'b1)
          is_lit, is_spike: begin
            data_q  <= bus.packet_in;
            spike_q <= is_spike;
            valid_q <= 1'b1;
            prev    <= bus.packet_in;
            has_ref <= 1'b1;
          end
          is_delta: begin
            data_q  <= sum;
            spike_q <= 1'b0;
            valid_q <= 1'b1;
            prev    <= sum;
            if (!has_ref) no_ref_err <= 1'b1;
          end
          is_run: begin
            // a zero-length run is swallowed here
            if (run_load) begin
              data_q  <= prev;
              spike_q <= 1'b0;
              valid_q <= 1'b1;
              if (!has_ref) no_ref_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (run_load) begin
        data_q  <= prev;
        spike_q <= 1'b0;
        valid_q <= 1'b1;
      end
    end
  end

`ifdef DECOMP_STATS_EN
  logic [15:0] sample_cnt, spike_cnt, run_cnt_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      spike_cnt  <= '0;
      run_cnt_s  <= '0;
    end else begin
      if (xfer) sample_cnt <= sample_cnt + 16'd1;
      if (xfer && spike_q) spike_cnt <= spike_cnt + 16'd1;
      if (acc && is_run && run_load) run_cnt_s <= run_cnt_s + 16'd1;
    end
  end

  assign stats = '{sample_count: sample_cnt,
                   spike_count:  spike_cnt,
                   run_count:    run_cnt_s,
                   no_ref_err:   no_ref_err};
`else
  assign stats = '{sample_count: 16'd0,
                   spike_count:  16'd0,
                   run_count:    16'd0,
                   no_ref_err:   no_ref_err};
`endif

endmodule

// File: tb/tb_delta_decompressor.sv
// Scoreboard bench for delta_decompressor: directed packets, queued
// expectations, and an independent output monitor.
module tb_delta_decompressor;
  import neural_compressor_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  decomp_stats_t stats;

  delta_decompressor_if #(.DATA_W(16)) bus ();

  delta_decompressor #(.DATA_W(16), .RUN_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .stats (stats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        s;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic s);
    exp_t e;
    e.d = d;
    e.s = s;
    q.push_back(e);
  endtask

  // Monitor: inspects the presented sample away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.valid_out) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected none",
                   bus.data_out);
        end else begin
          chk("data_out", bus.data_out, q[0].d);
          chk("spike_out", bus.spike_out, q[0].s);
          if (bus.ready_in) void'(q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [1:0] t, input logic [15:0] p,
                      output int waits);
    bus.packet_type = t;
    bus.packet_in   = p;
    bus.valid_in    = 1'b1;
    waits = 0;
    #1;
    while (!bus.ready_out && waits < 40) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!bus.ready_out) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready_out=0 expected 1");
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", q.size(), 0);
    @(negedge clk);
    #1;
    chk("idle_valid", bus.valid_out, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    repeat (2) @(negedge clk);
    q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bus.valid_in    = 1'b0;
    bus.ready_in    = 1'b1;
    bus.packet_in   = '0;
    bus.packet_type = PKT_LITERAL;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_spike", bus.spike_out, 0);
    chk("rst_stats", 64'(stats), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", bus.ready_out, 1);
    @(negedge clk);

    // literal, positive delta, negative delta
    push(16'd100, 1'b0);
    send(PKT_LITERAL, 16'd100, w);
    chk("t1_w0", w, 0);
    push(16'd105, 1'b0);
    send(PKT_DELTA, 16'd5, w);
    chk("t1_w1", w, 0);
    push(16'd95, 1'b0);
    send(PKT_DELTA, 16'hFFF6, w);
    chk("t1_w2", w, 0);
    drain();
    chk("t1_noref", stats.no_ref_err, 0);

    // run of three
    for (int i = 0; i < 4; i++) push(16'd50, 1'b0);
    send(PKT_LITERAL, 16'd50, w);
    send(PKT_RUN, 16'd3, w);
    chk("t2_run_w", w, 0);
    push(16'd7, 1'b0);
    send(PKT_LITERAL, 16'd7, w);
    chk("t2_stall", w, 2);
    drain();
`ifdef DECOMP_STATS_EN
    chk("t2_run_count", stats.run_count, 1);
`else
    chk("t2_run_count", stats.run_count, 0);
`endif

    // zero-length run
    push(16'd9, 1'b0);
    send(PKT_LITERAL, 16'd9, w);
    send(PKT_RUN, 16'd0, w);
    chk("t3_run0_w", w, 0);
    push(16'd10, 1'b0);
    send(PKT_DELTA, 16'd1, w);
    chk("t3_delta_w", w, 0);
    drain();

    // wrap and missing reference
    push(16'h7FFF, 1'b0);
    send(PKT_LITERAL, 16'h7FFF, w);
    push(16'h8000, 1'b0);
    send(PKT_DELTA, 16'd1, w);
    drain();
    chk("t4_noref0", stats.no_ref_err, 0);
    do_reset();
    push(16'd4, 1'b0);
    send(PKT_DELTA, 16'd4, w);
    drain();
    chk("t4_noref1", stats.no_ref_err, 1);
    push(16'd1, 1'b0);
    send(PKT_LITERAL, 16'd1, w);
    drain();
    chk("t4_sticky", stats.no_ref_err, 1);

    // spike held through stalls
    do_reset();
    push(16'd300, 1'b1);
    push(16'd302, 1'b0);
    send(PKT_SPIKE, 16'd300, w);
    fork
      send(PKT_DELTA, 16'd2, w);
      begin
        bus.ready_in = 1'b0;
        @(negedge clk);
        bus.ready_in = 1'b0;
        @(negedge clk);
        bus.ready_in = 1'b1;
      end
    join
    chk("t5_stall", w, 2);
    drain();
`ifdef DECOMP_STATS_EN
    chk("t5_samples", stats.sample_count, 2);
    chk("t5_spikes", stats.spike_count, 1);
`else
    chk("t5_samples", stats.sample_count, 0);
    chk("t5_spikes", stats.spike_count, 0);
`endif

    // reset in the middle of a run
    do_reset();
    push(16'd20, 1'b0);
    for (int i = 0; i < 5; i++) push(16'd20, 1'b0);
    send(PKT_LITERAL, 16'd20, w);
    send(PKT_RUN, 16'd5, w);
    @(negedge clk);
    @(negedge clk);
    bus.ready_in = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("t6_pending", q.size(), 3);
    chk("t6_valid", bus.valid_out, 0);
    chk("t6_data", bus.data_out, 0);
    chk("t6_spike", bus.spike_out, 0);
    chk("t6_stats", 64'(stats), 0);
    chk("t6_ready", bus.ready_out, 1);
    q.delete();
    @(negedge clk);
    bus.ready_in = 1'b1;
    rst_n = 1'b1;
    push(16'd3, 1'b0);
    send(PKT_DELTA, 16'd3, w);
    drain();
    chk("t6_noref", stats.no_ref_err, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
